// File: rtl/dla_noc_packetizer_pkg.sv
// rtl/dla_noc_packetizer_pkg.sv - shared flit types, field sizes and head-field offsets
package dla_noc_packetizer_pkg;

  localparam int FLIT_DATA_SIZE   = 32;
  localparam int FLIT_LABEL_SIZE  = 2;
  localparam int FLIT_TOTAL_SIZE  = FLIT_LABEL_SIZE + FLIT_DATA_SIZE;

  localparam int DEST_ADDR_SIZE_X = 3;
  localparam int DEST_ADDR_SIZE_Y = 3;
  localparam int DEST_ADDR_SIZE_L = 2;
  localparam int DLA_IDX_SIZE     = 2;

  // Head-flit field placement, shared with the fifo/router bridge decoder
  localparam int HEAD_L_OFS   = 0;
  localparam int HEAD_Y_OFS   = DEST_ADDR_SIZE_L;
  localparam int HEAD_X_OFS   = DEST_ADDR_SIZE_L + DEST_ADDR_SIZE_Y;
  localparam int HEAD_PL_OFS  = DEST_ADDR_SIZE_L + DEST_ADDR_SIZE_Y + DEST_ADDR_SIZE_X;
  localparam int HEAD_PL_SIZE = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + DLA_IDX_SIZE;

  typedef enum logic [FLIT_LABEL_SIZE-1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HEAD  = 2'b01,
    ST_BODY  = 2'b10,
    ST_GRANT = 2'b11
  } pktz_state_t;

  // Destination fields packed into the low bits of a head flit; everything else zero
  function automatic logic [FLIT_DATA_SIZE-1:0] head_data(
    input logic [DEST_ADDR_SIZE_X-1:0] x,
    input logic [DEST_ADDR_SIZE_Y-1:0] y,
    input logic [DEST_ADDR_SIZE_L-1:0] l
  );
    logic [FLIT_DATA_SIZE-1:0] d;
    d = '0;
    d[HEAD_L_OFS +: DEST_ADDR_SIZE_L] = l;
    d[HEAD_Y_OFS +: DEST_ADDR_SIZE_Y] = y;
    d[HEAD_X_OFS +: DEST_ADDR_SIZE_X] = x;
    return d;
  endfunction

endpackage

// File: rtl/dla_noc_packetizer_if.sv
// rtl/dla_noc_packetizer_if.sv - DLA-side request, payload and grant handshakes
interface dla_noc_packetizer_if
  import dla_noc_packetizer_pkg::*;
#(
  parameter int LEN_W = 8
);

  logic                        req_vld;
  logic                        req_rdy;
  logic [DEST_ADDR_SIZE_X-1:0] req_x;
  logic [DEST_ADDR_SIZE_Y-1:0] req_y;
  logic [DEST_ADDR_SIZE_L-1:0] req_l;
  logic [LEN_W-1:0]            req_len;

  logic                        pl_vld;
  logic                        pl_rdy;
  logic [FLIT_DATA_SIZE-1:0]   pl_data;

  logic                        gnt_vld;
  logic                        gnt_rdy;
  logic [DEST_ADDR_SIZE_X-1:0] gnt_dst_x;
  logic [DEST_ADDR_SIZE_Y-1:0] gnt_dst_y;
  logic [DEST_ADDR_SIZE_L-1:0] gnt_dst_l;
  logic [DEST_ADDR_SIZE_X-1:0] gnt_src_x;
  logic [DEST_ADDR_SIZE_Y-1:0] gnt_src_y;
  logic [DLA_IDX_SIZE-1:0]     gnt_src_dla;

  modport master (
    output req_vld, req_x, req_y, req_l, req_len,
    input  req_rdy,
    output pl_vld, pl_data,
    input  pl_rdy,
    output gnt_vld, gnt_dst_x, gnt_dst_y, gnt_dst_l, gnt_src_x, gnt_src_y, gnt_src_dla,
    input  gnt_rdy
  );

  modport slave (
    input  req_vld, req_x, req_y, req_l, req_len,
    output req_rdy,
    input  pl_vld, pl_data,
    output pl_rdy,
    input  gnt_vld, gnt_dst_x, gnt_dst_y, gnt_dst_l, gnt_src_x, gnt_src_y, gnt_src_dla,
    output gnt_rdy
  );

endinterface

// File: rtl/noc_sat_counter.sv
// rtl/noc_sat_counter.sv - saturating event counter
module noc_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  // Count events, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dla_noc_packetizer.sv
// rtl/dla_noc_packetizer.sv - DLA flit packetizer into router-input FIFO (optional NOC_PKTZ_STATS_EN)
module dla_noc_packetizer
  import dla_noc_packetizer_pkg::*;
#(
  parameter int LEN_W      = 8,
  parameter bit GRANT_PRIO = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  dla_noc_packetizer_if.slave        dla,
  input  logic                       fifo_full,
  output logic                       fifo_wen,
  output logic [FLIT_TOTAL_SIZE-1:0] fifo_wdata,
  output logic                       busy
`ifdef NOC_PKTZ_STATS_EN
  ,
  output logic [15:0]                stat_pkt_cnt,
  output logic [15:0]                stat_gnt_cnt
`endif
);

  pktz_state_t                 state;
  logic [LEN_W-1:0]            rem;
  logic [DEST_ADDR_SIZE_X-1:0] hdr_x;
  logic [DEST_ADDR_SIZE_Y-1:0] hdr_y;
  logic [DEST_ADDR_SIZE_L-1:0] hdr_l;
  logic [DEST_ADDR_SIZE_X-1:0] src_x;
  logic [DEST_ADDR_SIZE_Y-1:0] src_y;
  logic [DLA_IDX_SIZE-1:0]     src_dla;

  logic pick_gnt;
  logic pick_req;
  logic last_beat;

  // Arbitration between a pending grant and a pending request; only one wins per IDLE cycle
  assign pick_gnt  = dla.gnt_vld && (GRANT_PRIO || !dla.req_vld);
  assign pick_req  = dla.req_vld && !pick_gnt;
  assign last_beat = (rem == LEN_W'(1));

  assign dla.req_rdy = (state == ST_IDLE) && pick_req;
  assign dla.gnt_rdy = (state == ST_IDLE) && pick_gnt;
  assign dla.pl_rdy  = (state == ST_BODY) && !fifo_full;
  assign busy        = (state != ST_IDLE);

  // FIFO write port is derived from registered state so it holds steady while full
  always_comb begin
    logic [FLIT_DATA_SIZE-1:0] d;
    d          = head_data(hdr_x, hdr_y, hdr_l);
    fifo_wen   = 1'b0;
    fifo_wdata = '0;
    case (state)
      ST_HEAD: begin
        fifo_wen   = !fifo_full;
        fifo_wdata = {HEAD, d};
      end
      ST_BODY: begin
        fifo_wen   = !fifo_full && dla.pl_vld;
        fifo_wdata = {(last_beat ? TAIL : BODY), dla.pl_data};
      end
      ST_GRANT: begin
        d[HEAD_PL_OFS +: HEAD_PL_SIZE] = {src_x, src_y, src_dla};
        fifo_wen   = !fifo_full;
        fifo_wdata = {HEADTAIL, d};
      end
      default: begin
        fifo_wen   = 1'b0;
        fifo_wdata = '0;
      end
    endcase
  end

  // Packet sequencer: capture accepted fields, walk HEAD/BODY or GRANT, return to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rem     <= '0;
      hdr_x   <= '0;
      hdr_y   <= '0;
      hdr_l   <= '0;
      src_x   <= '0;
      src_y   <= '0;
      src_dla <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_gnt) begin
            hdr_x   <= dla.gnt_dst_x;
            hdr_y   <= dla.gnt_dst_y;
            hdr_l   <= dla.gnt_dst_l;
            src_x   <= dla.gnt_src_x;
            src_y   <= dla.gnt_src_y;
            src_dla <= dla.gnt_src_dla;
            state   <= ST_GRANT;
          end else if (pick_req) begin
            hdr_x <= dla.req_x;
            hdr_y <= dla.req_y;
            hdr_l <= dla.req_l;
            rem   <= (dla.req_len == '0) ? LEN_W'(1) : dla.req_len;
            state <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (!fifo_full) state <= ST_BODY;
        end
        ST_BODY: begin
          if (dla.pl_vld && !fifo_full) begin
            rem <= rem - LEN_W'(1);
            if (last_beat) state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (!fifo_full) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef NOC_PKTZ_STATS_EN
  logic tail_wr;
  logic ht_wr;

  assign tail_wr = fifo_wen && (state == ST_BODY) && last_beat;
  assign ht_wr   = fifo_wen && (state == ST_GRANT);

  noc_sat_counter #(.WIDTH(16)) u_pkt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (tail_wr),
    .cnt   (stat_pkt_cnt)
  );

  noc_sat_counter #(.WIDTH(16)) u_gnt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ht_wr),
    .cnt   (stat_gnt_cnt)
  );
`endif

endmodule

// File: tb/tb_dla_noc_packetizer.sv
// tb/tb_dla_noc_packetizer.sv - randomized flit-stream bench with queue reference model
module tb_dla_noc_packetizer;
  import dla_noc_packetizer_pkg::*;

  localparam int LEN_W = 8;
  localparam int LIM   = 4000;
  localparam int LS    = DEST_ADDR_SIZE_L;
  localparam int YS    = DEST_ADDR_SIZE_Y;
  localparam int XS    = DEST_ADDR_SIZE_X;

  typedef logic [FLIT_TOTAL_SIZE-1:0] word_t;
  typedef logic [FLIT_DATA_SIZE-1:0]  data_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  fifo_full = 1'b0;
  logic  fifo_wen;
  word_t fifo_wdata;
  logic  busy;
`ifdef NOC_PKTZ_STATS_EN
  logic [15:0] stat_pkt_cnt;
  logic [15:0] stat_gnt_cnt;
`endif

  dla_noc_packetizer_if #(.LEN_W(LEN_W)) dla ();

  dla_noc_packetizer #(.LEN_W(LEN_W), .GRANT_PRIO(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dla        (dla),
    .fifo_full  (fifo_full),
    .fifo_wen   (fifo_wen),
    .fifo_wdata (fifo_wdata),
    .busy       (busy)
`ifdef NOC_PKTZ_STATS_EN
    ,
    .stat_pkt_cnt (stat_pkt_cnt),
    .stat_gnt_cnt (stat_gnt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errs = 0;
  word_t exp_q[$];
  word_t wlog[$];
  int    gnt_pulses = 0;
  int    tails_seen = 0;
  int    gnts_seen = 0;
  bit    full_rand = 1'b0;
  int    full_pct = 0;

  // Reference encoding: plain arithmetic on the field positions
  function automatic data_t head_val(int x, int y, int l);
    return data_t'(l + y * (1 << LS) + x * (1 << (LS + YS)));
  endfunction

  function automatic data_t grant_val(int dx, int dy, int dl, int sx, int sy, int sd);
    return head_val(dx, dy, dl) + data_t'((sx * (1 << (YS + 2)) + sy * 4 + sd) * (1 << (LS + YS + XS)));
  endfunction

  function automatic word_t mk(flit_label_t lb, data_t d);
    return {lb, d};
  endfunction

  function automatic word_t logat(int i);
    if (i < wlog.size()) return wlog[i];
    return 'x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errs++;
    $display("FAIL %s timeout", name);
  endtask

  // Every written flit must be the next one the model predicts
  always @(negedge clk) begin
    if (rst_n) begin
      if (dla.gnt_rdy) gnt_pulses++;
      if (fifo_wen) begin
        word_t e;
        checks++;
        if (fifo_full) begin
          errs++;
          $display("FAIL wen_while_full actual=1 required=0");
        end else if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_write actual=%0h required=none", fifo_wdata);
        end else begin
          e = exp_q.pop_front();
          wlog.push_back(fifo_wdata);
          if (e[FLIT_TOTAL_SIZE-1 -: 2] == TAIL) tails_seen++;
          if (e[FLIT_TOTAL_SIZE-1 -: 2] == HEADTAIL) gnts_seen++;
          if (fifo_wdata !== e) begin
            errs++;
            $display("FAIL flit actual=%0h required=%0h", fifo_wdata, e);
          end
        end
      end
    end
  end

  // Downstream FIFO back-pressure
  always @(posedge clk) begin
    #1;
    fifo_full = full_rand ? ($urandom_range(0, 99) < full_pct) : 1'b0;
  end

  task automatic req_hs();
    int t = 0;
    dla.req_vld = 1'b1;
    while (1) begin
      @(negedge clk);
      if (dla.req_rdy) break;
      if (++t > LIM) begin timeout("req_hs"); break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    dla.req_vld = 1'b0;
  endtask

  task automatic gnt_hs();
    int t = 0;
    dla.gnt_vld = 1'b1;
    while (1) begin
      @(negedge clk);
      if (dla.gnt_rdy) break;
      if (++t > LIM) begin timeout("gnt_hs"); break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    dla.gnt_vld = 1'b0;
  endtask

  task automatic pl_stream(input data_t beats[$], input int gap);
    int i = 0;
    int t = 0;
    while (i < beats.size()) begin
      dla.pl_vld  = ($urandom_range(0, 99) >= gap);
      dla.pl_data = beats[i];
      @(negedge clk);
      if (dla.pl_vld && dla.pl_rdy) i++;
      @(posedge clk); #1;
      if (++t > LIM) begin timeout("pl_stream"); break; end
    end
    dla.pl_vld  = 1'b0;
    dla.pl_data = '0;
  endtask

  task automatic push_pkt(input int x, input int y, input int l, input int len, output data_t beats[$]);
    int n = (len == 0) ? 1 : len;
    beats = {};
    exp_q.push_back(mk(HEAD, head_val(x, y, l)));
    for (int i = 0; i < n; i++) begin
      data_t d = $urandom;
      beats.push_back(d);
      exp_q.push_back(mk((i == n - 1) ? TAIL : BODY, d));
    end
    dla.req_x   = x[XS-1:0];
    dla.req_y   = y[YS-1:0];
    dla.req_l   = l[LS-1:0];
    dla.req_len = len[LEN_W-1:0];
  endtask

  task automatic set_gnt(input int dx, input int dy, input int dl, input int sx, input int sy, input int sd);
    exp_q.push_back(mk(HEADTAIL, grant_val(dx, dy, dl, sx, sy, sd)));
    dla.gnt_dst_x   = dx[XS-1:0];
    dla.gnt_dst_y   = dy[YS-1:0];
    dla.gnt_dst_l   = dl[LS-1:0];
    dla.gnt_src_x   = sx[XS-1:0];
    dla.gnt_src_y   = sy[YS-1:0];
    dla.gnt_src_dla = sd[1:0];
  endtask

  task automatic send_req(input int x, input int y, input int l, input int len, input int gap);
    data_t b[$];
    push_pkt(x, y, l, len, b);
    req_hs();
    pl_stream(b, gap);
  endtask

  task automatic send_gnt(input int dx, input int dy, input int dl, input int sx, input int sy, input int sd);
    set_gnt(dx, dy, dl, sx, sy, sd);
    gnt_hs();
  endtask

  task automatic wait_drain();
    int t = 0;
    while (1) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !busy) break;
      if (++t > LIM) begin timeout("drain"); break; end
    end
  endtask

  initial begin
    int base;
    int gp;
    data_t b[$];
    data_t b2[$];
    int t;

    dla.req_vld = 0; dla.req_x = 0; dla.req_y = 0; dla.req_l = 0; dla.req_len = 0;
    dla.pl_vld = 0; dla.pl_data = 0;
    dla.gnt_vld = 0; dla.gnt_dst_x = 0; dla.gnt_dst_y = 0; dla.gnt_dst_l = 0;
    dla.gnt_src_x = 0; dla.gnt_src_y = 0; dla.gnt_src_dla = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wen", fifo_wen, 0);
    check("rst_wdata", fifo_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_rdys", {dla.req_rdy, dla.gnt_rdy, dla.pl_rdy}, 0);
`ifdef NOC_PKTZ_STATS_EN
    check("rst_stats", {stat_pkt_cnt, stat_gnt_cnt}, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    check("model_head", head_val(3, 5, 2), 32'h76);
    check("model_grant", grant_val(1, 1, 0, 7, 2, 3), 32'hEB24);

    // Basic three-beat packet
    base = wlog.size();
    send_req(3, 5, 2, 3, 0);
    wait_drain();
    check("t1_busy", busy, 0);
    check("t1_count", wlog.size() - base, 4);
    check("t1_head", logat(base), {2'b00, 32'h0000_0076});
    check("t1_tail_lbl", logat(base + 3) >> FLIT_DATA_SIZE, 2'b10);

    // Single-beat and zero-length packets
    base = wlog.size();
    send_req(1, 2, 3, 1, 0);
    wait_drain();
    check("t2_len1_count", wlog.size() - base, 2);
    base = wlog.size();
    send_req(4, 0, 1, 0, 0);
    wait_drain();
    check("t2_len0_count", wlog.size() - base, 2);
    check("t2_len0_tail_lbl", logat(base + 1) >> FLIT_DATA_SIZE, 2'b10);

    // Grant flit
    gp = gnt_pulses;
    base = wlog.size();
    send_gnt(1, 1, 0, 7, 2, 3);
    wait_drain();
    check("t3_gnt_pulses", gnt_pulses - gp, 1);
    check("t3_flit", logat(base), {2'b11, 32'h0000_EB24});

    // Simultaneous grant and request: grant goes first
    set_gnt(2, 3, 1, 5, 4, 2);
    push_pkt(6, 1, 2, 2, b);
    dla.req_vld = 1'b1;
    dla.gnt_vld = 1'b1;
    @(negedge clk);
    check("t4_both_rdy", {dla.gnt_rdy, dla.req_rdy}, 2'b10);
    @(posedge clk); #1;
    dla.gnt_vld = 1'b0;
    req_hs();
    pl_stream(b, 0);
    wait_drain();

    // Grant raised mid-packet waits for the tail
    push_pkt(0, 7, 0, 4, b);
    req_hs();
    set_gnt(7, 7, 3, 1, 0, 1);
    dla.gnt_vld = 1'b1;
    pl_stream(b, 30);
    gnt_hs();
    wait_drain();

    // Random mix under back-pressure and payload gaps
    full_rand = 1'b1;
    full_pct  = 40;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0)
        send_gnt($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
      else
        send_req($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
                 $urandom_range(0, 6), 30);
    end
    send_req(5, 5, 1, 255, 20);
    wait_drain();
    full_rand = 1'b0;
    check("t5_queue_empty", exp_q.size(), 0);
`ifdef NOC_PKTZ_STATS_EN
    check("t5_stat_pkt", stat_pkt_cnt, tails_seen);
    check("t5_stat_gnt", stat_gnt_cnt, gnts_seen);
`endif

    // Reset in the middle of a payload
    @(posedge clk); #1;
    push_pkt(3, 3, 3, 5, b);
    req_hs();
    b2 = b[0:1];
    pl_stream(b2, 0);
    t = 0;
    while (exp_q.size() > 3) begin
      @(posedge clk); #2;
      if (++t > LIM) begin timeout("t6_partial"); break; end
    end
    check("t6_partial_left", exp_q.size(), 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs", {fifo_wen, busy, dla.pl_rdy}, 0);
    check("t6_rst_wdata", fifo_wdata, 0);
    exp_q.delete();
    tails_seen = 0;
    gnts_seen = 0;
`ifdef NOC_PKTZ_STATS_EN
    check("t6_rst_stats", {stat_pkt_cnt, stat_gnt_cnt}, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = wlog.size();
    send_req(2, 6, 1, 1, 0);
    wait_drain();
    check("t6_clean_head", logat(base), {2'b00, 32'h0000_0059});
    check("t6_count", wlog.size() - base, 2);
`ifdef NOC_PKTZ_STATS_EN
    check("t6_stat_pkt", stat_pkt_cnt, 1);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
